// File: rtl/astro_pkg.sv
// Shared types and constants for the cartridge/BIOS ROM loaders.
package astro_pkg;

  localparam int         ROM_BYTES = 8192;
  localparam int         ROM_AW    = 13;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MIR_RD,
    S_MIR_LAT,
    S_MIR_WR,
    S_FILL
  } loader_state_t;

endpackage

// File: rtl/cart_loader.sv
// Owns the 8 KB cart ROM write port: captures an ioctl download, then mirrors
// short images (or fills with 0xFF) across the window; passes cart_addr otherwise.
module cart_loader
  import astro_pkg::*;
#(
  parameter logic [7:0] INDEX  = 8'd1,
  parameter bit         MIRROR = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_l,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [ROM_AW-1:0] cart_addr,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_wdata,
  output logic              rom_we,
  input  logic [7:0]        rom_rdata,
  output logic              busy,
  output logic [13:0]       cart_size
);

  localparam logic [13:0] FULL_SIZE = 14'(ROM_BYTES);

  loader_state_t     state_reg, state_next;
  logic [13:0]       size_reg;
  logic [ROM_AW-1:0] src_reg, dst_reg, wr_addr_reg;
  logic [7:0]        wr_data_reg, mir_data_reg;
  logic              wr_en_reg, busy_reg;

  logic        index_hit, wr_ok;
  logic [13:0] wr_end;

  assign index_hit = ioctl_download && (ioctl_index == INDEX);
  // Only bytes arriving while the download is still flagged count, so the
  // size sampled at the falling edge is always final.
  assign wr_ok  = (state_reg == S_LOAD) && ioctl_download && ioctl_wr &&
                  (ioctl_addr < 25'(ROM_BYTES));
  assign wr_end = {1'b0, ioctl_addr[ROM_AW-1:0]} + 14'd1;

  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: if (index_hit) state_next = S_LOAD;
      S_LOAD: begin
        if (!ioctl_download) begin
          if (!MIRROR || size_reg == FULL_SIZE) state_next = S_IDLE;
          else if (size_reg == 14'd0)           state_next = S_FILL;
          else                                  state_next = S_MIR_RD;
        end
      end
      S_MIR_RD:  state_next = S_MIR_LAT;
      S_MIR_LAT: state_next = S_MIR_WR;
      S_MIR_WR:  state_next = (dst_reg == '1) ? S_IDLE : S_MIR_RD;
      S_FILL:    state_next = (dst_reg == '1) ? S_IDLE : S_FILL;
      default:   state_next = S_IDLE;
    endcase
    // A fresh download for this index pre-empts any post-processing.
    if (index_hit && state_reg != S_IDLE && state_reg != S_LOAD)
      state_next = S_LOAD;
  end

  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      busy_reg     <= 1'b0;
      size_reg     <= '0;
      src_reg      <= '0;
      dst_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      mir_data_reg <= '0;
    end else begin
      busy_reg  <= (state_next != S_IDLE);
      wr_en_reg <= wr_ok;
      if (wr_ok) begin
        wr_addr_reg <= ioctl_addr[ROM_AW-1:0];
        wr_data_reg <= ioctl_dout;
        if (wr_end > size_reg) size_reg <= wr_end;
      end
      if (state_next == S_LOAD && state_reg != S_LOAD) size_reg <= '0;
      case (state_reg)
        // size[12:0] is the mirror start, and is 0 for the fill case.
        S_LOAD: begin
          src_reg <= '0;
          dst_reg <= size_reg[ROM_AW-1:0];
        end
        S_MIR_LAT: mir_data_reg <= rom_rdata;
        S_MIR_WR: begin
          dst_reg <= dst_reg + 1'b1;
          src_reg <= (({1'b0, src_reg} + 14'd1) == size_reg) ? '0 : src_reg + 1'b1;
        end
        S_FILL:  dst_reg <= dst_reg + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rom_addr  = cart_addr;
    rom_wdata = wr_data_reg;
    rom_we    = 1'b0;
    unique case (state_reg)
      S_IDLE: ;
      S_LOAD: begin
        rom_addr = wr_addr_reg;
        rom_we   = wr_en_reg;
      end
      S_MIR_RD, S_MIR_LAT: rom_addr = src_reg;
      S_MIR_WR: begin
        rom_addr  = dst_reg;
        rom_wdata = mir_data_reg;
        rom_we    = 1'b1;
      end
      S_FILL: begin
        rom_addr  = dst_reg;
        rom_wdata = FILL_BYTE;
        rom_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = busy_reg;
  assign cart_size = size_reg;

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: a cart instance (INDEX 1, mirroring) and a BIOS
// instance (INDEX 0, no mirroring) share one ioctl bus, each with its own ROM.
`timescale 1ns/1ps
module tb_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset_l = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [12:0] cart_addr = '0;

  logic [12:0] rom_addr_c, rom_addr_b;
  logic [7:0]  wdata_c, wdata_b, rdata_c, rdata_b;
  logic        we_c, we_b, busy_c, busy_b;
  logic [13:0] size_c, size_b;

  always #5 clk_sys = ~clk_sys;

  cart_loader #(.INDEX(8'd1), .MIRROR(1'b1)) dut_cart (
    .clk_sys(clk_sys), .reset_l(reset_l), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .cart_addr(cart_addr), .rom_addr(rom_addr_c),
    .rom_wdata(wdata_c), .rom_we(we_c), .rom_rdata(rdata_c), .busy(busy_c),
    .cart_size(size_c)
  );

  cart_loader #(.INDEX(8'd0), .MIRROR(1'b0)) dut_bios (
    .clk_sys(clk_sys), .reset_l(reset_l), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .cart_addr(cart_addr), .rom_addr(rom_addr_b),
    .rom_wdata(wdata_b), .rom_we(we_b), .rom_rdata(rdata_b), .busy(busy_b),
    .cart_size(size_b)
  );

  // Dual-port RAM models with registered read, plus activity counters.
  logic [7:0] rom_c [8192];
  logic [7:0] rom_b [8192];
  int we_cnt_c = 0, we_cnt_b = 0, busy_cyc_c = 0;

  always @(posedge clk_sys) begin
    if (we_c) rom_c[rom_addr_c] <= wdata_c;
    if (we_b) rom_b[rom_addr_b] <= wdata_b;
    rdata_c <= rom_c[rom_addr_c];
    rdata_b <= rom_b[rom_addr_b];
    if (we_c)   we_cnt_c   <= we_cnt_c + 1;
    if (we_b)   we_cnt_b   <= we_cnt_b + 1;
    if (busy_c) busy_cyc_c <= busy_cyc_c + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] img [9000];

  // Expected cart ROM after a download of n bytes: the image repeated modulo n.
  function automatic logic [7:0] exp_cart(int k, int n);
    if (n == 0)    return 8'hFF;
    if (n >= 8192) return img[k];
    return img[k % n];
  endfunction

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic load_image(input int n, input logic [7:0] idx, input bit pattern,
                            input bit gaps);
    for (int k = 0; k < n; k++)
      img[k] = pattern ? (8'(k) ^ 8'h5A) : 8'($urandom);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    for (int k = 0; k < n; k++) begin
      ioctl_addr = 25'(k);
      ioctl_dout = img[k];
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
      if (gaps && $urandom_range(0, 7) == 0) tick();
    end
    tick();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy_c && cyc < 30000) begin
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset;
    reset_l   = 1'b0;
    cart_addr = 13'($urandom);
    tick(); tick();
    n_cmp += 6;
    if (busy_c !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_c); end
    if (we_c !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", we_c); end
    if (wdata_c !== 8'h00) begin n_bad++; $display("FAIL reset_wdata: got %h want 00", wdata_c); end
    if (size_c !== 14'd0) begin n_bad++; $display("FAIL reset_size: got %0d want 0", size_c); end
    if (rom_addr_c !== cart_addr) begin n_bad++; $display("FAIL reset_addr: got %h want %h", rom_addr_c, cart_addr); end
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy_bios: got %b want 0", busy_b); end
    reset_l = 1'b1;
    tick();
    cart_addr = 13'($urandom);
    #1;
    n_cmp++;
    if (rom_addr_c !== cart_addr) begin n_bad++; $display("FAIL idle_passthrough: got %h want %h", rom_addr_c, cart_addr); end
    $display("test_reset done");
  endtask

  task automatic test_mirror_2k;
    int we0, cyc, bad, first;
    we0 = we_cnt_c;
    load_image(2048, 8'd1, 1'b1, 1'b1);
    n_cmp++;
    if (size_c !== 14'd2048) begin n_bad++; $display("FAIL m2k_size: got %0d want 2048", size_c); end
    wait_idle(cyc);
    n_cmp++;
    if (cyc != 18432) begin n_bad++; $display("FAIL m2k_busy_cycles: got %0d want 18432", cyc); end
    bad = 0; first = 0;
    for (int k = 0; k < 8192; k++)
      if (rom_c[k] !== exp_cart(k, 2048)) begin if (bad == 0) first = k; bad++; end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL m2k_rom: %0d bad, first %0d got %h want %h", bad, first, rom_c[first], exp_cart(first, 2048)); end
    n_cmp += 2;
    if (we_cnt_c - we0 != 8192) begin n_bad++; $display("FAIL m2k_we_count: got %0d want 8192", we_cnt_c - we0); end
    if (we_cnt_b != 0) begin n_bad++; $display("FAIL m2k_bios_quiet: got %0d writes want 0", we_cnt_b); end
    $display("test_mirror_2k done");
  endtask

  task automatic test_mirror_3000;
    int cyc, bad, first;
    load_image(3000, 8'd1, 1'b0, 1'b1);
    n_cmp++;
    if (size_c !== 14'd3000) begin n_bad++; $display("FAIL m3k_size: got %0d want 3000", size_c); end
    wait_idle(cyc);
    n_cmp++;
    if (cyc != 3 * (8192 - 3000)) begin n_bad++; $display("FAIL m3k_busy_cycles: got %0d want %0d", cyc, 3 * (8192 - 3000)); end
    n_cmp += 4;
    if (rom_c[3000] !== img[0]) begin n_bad++; $display("FAIL m3k_rom3000: got %h want %h", rom_c[3000], img[0]); end
    if (rom_c[5999] !== img[2999]) begin n_bad++; $display("FAIL m3k_rom5999: got %h want %h", rom_c[5999], img[2999]); end
    if (rom_c[6000] !== img[0]) begin n_bad++; $display("FAIL m3k_rom6000: got %h want %h", rom_c[6000], img[0]); end
    if (rom_c[8191] !== img[2191]) begin n_bad++; $display("FAIL m3k_rom8191: got %h want %h", rom_c[8191], img[2191]); end
    bad = 0; first = 0;
    for (int k = 0; k < 8192; k++)
      if (rom_c[k] !== exp_cart(k, 3000)) begin if (bad == 0) first = k; bad++; end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL m3k_rom: %0d bad, first %0d got %h want %h", bad, first, rom_c[first], exp_cart(first, 3000)); end
    $display("test_mirror_3000 done");
  endtask

  task automatic test_fill;
    int cyc, bad, first;
    load_image(0, 8'd1, 1'b0, 1'b0);
    n_cmp++;
    if (size_c !== 14'd0) begin n_bad++; $display("FAIL fill_size: got %0d want 0", size_c); end
    wait_idle(cyc);
    n_cmp++;
    if (cyc != 8192) begin n_bad++; $display("FAIL fill_busy_cycles: got %0d want 8192", cyc); end
    bad = 0; first = 0;
    for (int k = 0; k < 8192; k++)
      if (rom_c[k] !== 8'hFF) begin if (bad == 0) first = k; bad++; end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL fill_rom: %0d bad, first %0d got %h want ff", bad, first, rom_c[first]); end
    $display("test_fill done");
  endtask

  task automatic test_oversize;
    int we0, cyc, bad, first;
    we0 = we_cnt_c;
    load_image(9000, 8'd1, 1'b0, 1'b1);
    n_cmp += 2;
    if (size_c !== 14'd8192) begin n_bad++; $display("FAIL big_size: got %0d want 8192", size_c); end
    if (busy_c !== 1'b0) begin n_bad++; $display("FAIL big_no_mirror: busy got %b want 0", busy_c); end
    wait_idle(cyc);
    n_cmp++;
    if (we_cnt_c - we0 != 8192) begin n_bad++; $display("FAIL big_we_count: got %0d want 8192", we_cnt_c - we0); end
    bad = 0; first = 0;
    for (int k = 0; k < 8192; k++)
      if (rom_c[k] !== exp_cart(k, 9000)) begin if (bad == 0) first = k; bad++; end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL big_rom: %0d bad, first %0d got %h want %h", bad, first, rom_c[first], img[first]); end
    $display("test_oversize done");
  endtask

  task automatic test_back_to_back;
    int we0;
    logic [7:0] d;
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    tick();
    for (int k = 0; k < 256; k++) begin
      d          = 8'($urandom);
      ioctl_addr = 25'(k);
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      n_cmp += 3;
      if (we_c !== 1'b1) begin n_bad++; $display("FAIL b2b_we[%0d]: got %b want 1", k, we_c); end
      if (rom_addr_c !== 13'(k)) begin n_bad++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", k, rom_addr_c, k); end
      if (wdata_c !== d) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, wdata_c, d); end
    end
    ioctl_wr = 1'b0;
    tick();
    n_cmp++;
    if (we_c !== 1'b0) begin n_bad++; $display("FAIL b2b_we_drop: got %b want 0", we_c); end
    ioctl_download = 1'b0;
    tick();
    n_cmp++;
    if (size_c !== 14'd256) begin n_bad++; $display("FAIL b2b_size: got %0d want 256", size_c); end
    repeat (40) tick();
    n_cmp++;
    if (busy_c !== 1'b1) begin n_bad++; $display("FAIL b2b_mirroring: busy got %b want 1", busy_c); end
    #2 reset_l = 1'b0;
    #1;
    n_cmp += 3;
    if (busy_c !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b want 0", busy_c); end
    if (we_c !== 1'b0) begin n_bad++; $display("FAIL async_reset_we: got %b want 0", we_c); end
    if (size_c !== 14'd0) begin n_bad++; $display("FAIL async_reset_size: got %0d want 0", size_c); end
    we0 = we_cnt_c;
    repeat (3) tick();
    reset_l = 1'b1;
    repeat (20) tick();
    n_cmp += 2;
    if (we_cnt_c != we0) begin n_bad++; $display("FAIL post_reset_writes: got %0d want 0", we_cnt_c - we0); end
    if (busy_c !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", busy_c); end
    $display("test_back_to_back done");
  endtask

  task automatic test_bios;
    int wec0, bsy0, bad, first;
    logic [7:0] want;
    wec0 = we_cnt_c;
    bsy0 = busy_cyc_c;
    load_image(500, 8'd0, 1'b0, 1'b1);
    n_cmp += 5;
    if (size_b !== 14'd500) begin n_bad++; $display("FAIL bios_size: got %0d want 500", size_b); end
    if (busy_b !== 1'b0) begin n_bad++; $display("FAIL bios_busy_after: got %b want 0", busy_b); end
    if (we_cnt_b != 500) begin n_bad++; $display("FAIL bios_we_count: got %0d want 500", we_cnt_b); end
    if (we_cnt_c != wec0) begin n_bad++; $display("FAIL idx0_cart_writes: got %0d want 0", we_cnt_c - wec0); end
    if (busy_cyc_c != bsy0) begin n_bad++; $display("FAIL idx0_cart_busy: got %0d busy cycles want 0", busy_cyc_c - bsy0); end
    bad = 0; first = 0;
    for (int k = 0; k < 8192; k++) begin
      want = (k < 500) ? img[k] : 8'hC3;
      if (rom_b[k] !== want) begin if (bad == 0) first = k; bad++; end
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL bios_rom: %0d bad, first %0d got %h", bad, first, rom_b[first]); end
    $display("test_bios done");
  endtask

  task automatic test_abort;
    int cyc, bad, first;
    load_image(1000, 8'd1, 1'b0, 1'b1);
    repeat (100) tick();
    n_cmp++;
    if (busy_c !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy: got %b want 1", busy_c); end
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    tick();
    n_cmp += 3;
    if (busy_c !== 1'b1) begin n_bad++; $display("FAIL abort_load_busy: got %b want 1", busy_c); end
    if (size_c !== 14'd0) begin n_bad++; $display("FAIL abort_size_clear: got %0d want 0", size_c); end
    if (we_c !== 1'b0) begin n_bad++; $display("FAIL abort_we: got %b want 0", we_c); end
    load_image(7500, 8'd1, 1'b0, 1'b0);
    n_cmp++;
    if (size_c !== 14'd7500) begin n_bad++; $display("FAIL abort_reload_size: got %0d want 7500", size_c); end
    wait_idle(cyc);
    n_cmp++;
    if (cyc != 3 * 692) begin n_bad++; $display("FAIL abort_reload_cycles: got %0d want %0d", cyc, 3 * 692); end
    bad = 0; first = 0;
    for (int k = 0; k < 8192; k++)
      if (rom_c[k] !== exp_cart(k, 7500)) begin if (bad == 0) first = k; bad++; end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL abort_reload_rom: %0d bad, first %0d got %h want %h", bad, first, rom_c[first], exp_cart(first, 7500)); end
    $display("test_abort done");
  endtask

  initial begin
    for (int k = 0; k < 8192; k++) rom_b[k] = 8'hC3;
    test_reset();
    test_mirror_2k();
    test_mirror_3000();
    test_fill();
    test_oversize();
    test_back_to_back();
    test_bios();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
